seq_burst_ctrl: RTL and testbench

Parametrised serial pattern-triggered burst controller with integrated datapath. After a start handshake it watches a serial input for a programmable PAT_W-bit pattern, then runs a fixed-length up-count phase, loads a runtime value into a down-counter and counts it to zero. It sits in the latches/flip-flops lab datapath as the self-contained next generation of the split detector/up-counter/down-counter controller. It adds a configurable pattern, lengths and widths, a repeat mode, abort, and a burst counter.

---
 rtl/seq_burst_ctrl.sv | 147 ++++++++++++++
 tb/tb_seq_burst_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_burst_ctrl.sv
// seq_burst_ctrl: serial pattern-triggered burst controller.
// Waits for a start handshake, hunts for PATTERN on ser_in, then runs a
// fixed UP_LEN-cycle up-count, loads load_val and counts it down to zero.
// Supports repeat mode, abort and a saturating completed-burst counter.
module seq_burst_ctrl #(
  parameter int unsigned      PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int unsigned      UP_LEN  = 8,
  parameter int unsigned      CNT_W   = 8,
  parameter int unsigned      BURST_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               rpt,
  input  logic               ser_in,
  input  logic [CNT_W-1:0]   load_val,
  output logic               ready,
  output logic               busy,
  output logic               det,
  output logic               done,
  output logic [CNT_W-1:0]   up_cnt,
  output logic [CNT_W-1:0]   down_cnt,
  output logic [BURST_W-1:0] bursts,
  output logic [2:0]         state
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX   = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MATCH = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  UP_LAST    = CNT_W'(UP_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INIT      = 3'd1,
    S_DETECT    = 3'd2,
    S_UPCOUNT   = 3'd3,
    S_LOAD      = 3'd4,
    S_DOWNCOUNT = 3'd5
  } state_e;

  state_e             state_q, state_d;
  // Only the PAT_W-1 youngest bits are kept: the oldest one is shifted out
  // by the time the next comparison is made.
  logic [PAT_W-2:0]   shreg_q, shreg_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]   up_q, up_d;
  logic [CNT_W-1:0]   down_q, down_d;
  logic [BURST_W-1:0] bursts_q, bursts_d;
  logic [PAT_W-1:0]   nxt;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the old
    // values of the others at the same edge.
    if (rst) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      fill_q   <= '0;
      up_q     <= '0;
      down_q   <= '0;
      bursts_q <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      fill_q   <= fill_d;
      up_q     <= up_d;
      down_q   <= down_d;
      bursts_q <= bursts_d;
    end
  end

  // Next-state, datapath updates and Mealy det/done pulses.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned and infers a latch.
    state_d  = state_q;
    shreg_d  = shreg_q;
    fill_d   = fill_q;
    up_d     = up_q;
    down_d   = down_q;
    bursts_d = bursts_q;
    det      = 1'b0;
    done     = 1'b0;
    nxt      = {shreg_q, ser_in};

    if (abort && (state_q != S_IDLE)) begin
      // Abort drops the burst in progress but keeps the burst tally.
      state_d = S_IDLE;
      up_d    = '0;
      down_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) state_d = S_INIT;
        end
        S_INIT: begin
          shreg_d  = '0;
          fill_d   = '0;
          bursts_d = '0;
          if (!start) state_d = S_DETECT;
        end
        S_DETECT: begin
          shreg_d = nxt[PAT_W-2:0];
          if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
          // A match needs PAT_W fresh bits, counting the one on ser_in now.
          if ((nxt == PATTERN) && (fill_q >= FILL_MATCH)) begin
            det     = 1'b1;
            up_d    = '0;
            state_d = S_UPCOUNT;
          end
        end
        S_UPCOUNT: begin
          // The last value is held so it stays visible after the phase.
          if (up_q == UP_LAST) state_d = S_LOAD;
          else                 up_d    = up_q + 1'b1;
        end
        S_LOAD: begin
          down_d  = load_val;
          state_d = S_DOWNCOUNT;
        end
        S_DOWNCOUNT: begin
          if (down_q != '0) begin
            down_d = down_q - 1'b1;
          end else begin
            done = 1'b1;
            if (bursts_q != '1) bursts_d = bursts_q + 1'b1;
            // Start every pattern hunt from an empty history.
            shreg_d = '0;
            fill_d  = '0;
            state_d = rpt ? S_DETECT : S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign ready    = (state_q == S_IDLE);
  assign busy     = !ready;
  assign up_cnt   = up_q;
  assign down_cnt = down_q;
  assign bursts   = bursts_q;
  assign state    = state_q;

endmodule

// File: tb/tb_seq_burst_ctrl.sv
// Directed testbench for seq_burst_ctrl: default instance plus a
// PAT_W=6 / UP_LEN=1 / CNT_W=4 instance for the parameter sweep.
module tb_seq_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  // Default-parameter instance signals.
  logic       start = 1'b0, abort = 1'b0, rpt = 1'b0, ser_in = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic       ready, busy, det, done;
  logic [7:0] up_cnt, down_cnt;
  logic [3:0] bursts;
  logic [2:0] state;

  // Parameter-sweep instance signals.
  logic       start2 = 1'b0, abort2 = 1'b0, rpt2 = 1'b0, ser2 = 1'b0;
  logic [3:0] load2 = 4'd0;
  logic       ready2, busy2, det2, done2;
  logic [3:0] up2, down2;
  logic [3:0] bursts2;
  logic [2:0] state2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_burst_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .rpt(rpt),
    .ser_in(ser_in), .load_val(load_val), .ready(ready), .busy(busy),
    .det(det), .done(done), .up_cnt(up_cnt), .down_cnt(down_cnt),
    .bursts(bursts), .state(state)
  );

  seq_burst_ctrl #(
    .PAT_W(6), .PATTERN(6'b110010), .UP_LEN(1), .CNT_W(4), .BURST_W(4)
  ) u_dut6 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .rpt(rpt2),
    .ser_in(ser2), .load_val(load2), .ready(ready2), .busy(busy2),
    .det(det2), .done(done2), .up_cnt(up2), .down_cnt(down2),
    .bursts(bursts2), .state(state2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // IDLE -> INIT -> DETECT with a single-cycle start pulse.
  task automatic run_to_detect();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  // Feed n bits (MSB first) into the default instance, expecting det only
  // on the last one; ends one edge later, in UPCOUNT.
  task automatic feed(input logic [15:0] bits, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      ser_in = bits[n-1-i];
      #1;
      check(tag, det, (i == n - 1) ? 1 : 0);
      tick();
    end
    ser_in = 1'b0;
  endtask

  initial begin
    int edges;
    int first_up;
    logic [6:0] sweep_pat;

    // Reset state.
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_state", state, 0);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_det", det, 0);
    check("rst_done", done, 0);
    check("rst_up", up_cnt, 0);
    check("rst_down", down_cnt, 0);
    check("rst_bursts", bursts, 0);

    // Basic burst: start high 3 cycles, pattern 1011, load_val=3.
    start = 1'b1;
    tick();
    check("init_state", state, 1);
    check("init_busy", busy, 1);
    check("init_ready", ready, 0);
    tick();
    tick();
    check("init_hold", state, 1);
    start = 1'b0;
    tick();
    check("detect_entry", state, 2);
    feed(16'b1011, 4, "det_basic");
    for (int k = 0; k < 8; k++) begin
      check("up_state", state, 3);
      check("up_val", up_cnt, k);
      tick();
    end
    check("load_state", state, 4);
    check("up_hold", up_cnt, 7);
    load_val = 8'd3;
    tick();
    load_val = 8'd9;  // must not affect the running count
    for (int d = 3; d >= 0; d--) begin
      #1;
      check("down_state", state, 5);
      check("down_val", down_cnt, d);
      check("done_pulse", done, (d == 0) ? 1 : 0);
      tick();
    end
    check("after_done_state", state, 0);
    check("after_done_bursts", bursts, 1);
    check("after_done_done", done, 0);

    // Overlapping stream: 101011 matches only on the sixth bit.
    run_to_detect();
    check("ovl_detect", state, 2);
    feed(16'b101011, 6, "det_overlap");
    check("ovl_up", state, 3);

    // Reset in the middle of DOWNCOUNT with down_cnt=5.
    for (int k = 0; k < 8; k++) tick();
    load_val = 8'd5;
    tick();
    check("mid_down_val", down_cnt, 5);
    check("mid_down_state", state, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_state", state, 0);
    check("midrst_ready", ready, 1);
    check("midrst_up", up_cnt, 0);
    check("midrst_down", down_cnt, 0);
    check("midrst_bursts", bursts, 0);

    // Repeat mode with load_val=0: 20 bursts, counter saturates at 15.
    rpt = 1'b1;
    load_val = 8'd0;
    run_to_detect();
    for (int b = 1; b <= 20; b++) begin
      feed(16'b1011, 4, "det_rpt");
      for (int k = 0; k < 8; k++) tick();
      check("rpt_load", state, 4);
      tick();
      check("rpt_done", done, 1);
      check("rpt_down", state, 5);
      tick();
      check("rpt_redetect", state, 2);
      check("rpt_bursts", bursts, (b > 15) ? 15 : b);
    end

    // Abort in UPCOUNT at up_cnt=4.
    rpt = 1'b0;
    feed(16'b1011, 4, "det_abort");
    for (int k = 0; k < 4; k++) tick();
    check("abort_pre_up", up_cnt, 4);
    abort = 1'b1;
    #1;
    check("abort_no_done", done, 0);
    tick();
    abort = 1'b0;
    check("abort_state", state, 0);
    check("abort_up", up_cnt, 0);
    check("abort_down", down_cnt, 0);
    check("abort_bursts", bursts, 15);

    // Abort in IDLE is ignored; abort in INIT returns to IDLE.
    abort = 1'b1;
    start = 1'b1;
    tick();
    check("abort_idle_start", state, 1);
    start = 1'b0;
    tick();
    abort = 1'b0;
    check("abort_init", state, 0);

    // Parameter sweep: pattern 110010, UP_LEN=1, load_val=15.
    sweep_pat = 7'b0110010;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    check("sw_detect", state2, 2);
    load2 = 4'd15;
    for (int i = 0; i < 6; i++) begin
      ser2 = sweep_pat[5-i];
      #1;
      check("sw_det", det2, (i == 5) ? 1 : 0);
      if (i < 5) tick();
    end
    edges = 0;
    first_up = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      edges++;
      if (edges == 1) first_up = (state2 == 3'd3) ? 1 : 0;
      if (edges == 2) check("sw_up_len", state2, 4);
      if (done2) break;
    end
    check("sw_first_up", first_up, 1);
    check("sw_det_to_done", edges, 18);
    check("sw_done", done2, 1);
    tick();
    check("sw_idle", state2, 0);
    check("sw_bursts", bursts2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
